// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: key-length encoding, Nk/Nr lookup, GF(2^8) xtime,
// and the FSM state type used by the key-schedule engine.
package aes_pkg;

  localparam int MAX_WORDS = 60;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nk_of = 4'd4;
      KEY_LEN_192: nk_of = 4'd6;
      KEY_LEN_256: nk_of = 4'd8;
      default:     nk_of = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nr_of = 4'd10;
      KEY_LEN_192: nr_of = 4'd12;
      KEY_LEN_256: nr_of = 4'd14;
      default:     nr_of = 4'd0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the top byte; row n holds entries 16n..16n+15.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_pos;

  assign bit_pos  = 11'd2047 - {in_byte, 3'b000};
  assign out_byte = SBOX[bit_pos -: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a word store,
// round keys read back through a registered, index-addressed port.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int RK_W   = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  output logic                  busy,
  output logic                  key_valid,
  output logic                  err,
  output logic [3:0]            num_rounds,
  input  logic [3:0]            rk_addr,
  output logic [RK_W-1:0]       rk_data
);

  localparam int         DEPTH    = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  // Handshake: start is a request sampled only outside EXPAND; acceptance is implicit
  // (busy rises next cycle), rejection is signalled by a one-cycle err pulse.
  state_e           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [3:0]       j_q, j_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic [5:0]       last_q, last_d;
  logic             busy_q, busy_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q, err_d;
  logic [RK_W-1:0]  rk_data_q, rk_data_d;

  logic [31:0]      words_q [DEPTH];

  logic             load_en, wr_en, req_legal;
  logic [3:0]       req_nk;
  logic [31:0]      prev_w, back_w, sub_in, sub_out, temp_w, new_word;
  logic [5:0]       rd_base;

  assign req_nk    = nk_of(key_len);
  assign req_legal = (key_len != KEY_LEN_BAD) && (req_nk <= MAX_NK_L);

  assign prev_w = words_q[idx_q - 6'd1];
  assign back_w = words_q[idx_q - {2'b00, nk_q}];

  // RotWord only applies on the first word of each Nk group.
  assign sub_in = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    if (j_q == 4'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && j_q == 4'd4) begin
      temp_w = sub_out;
    end
  end

  assign new_word = back_w ^ temp_w;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    j_d         = j_q;
    rcon_d      = rcon_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    last_d      = last_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    load_en     = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (req_legal) begin
            nk_d        = req_nk;
            nr_d        = nr_of(key_len);
            last_d      = {nr_of(key_len), 2'b11};
            idx_d       = {2'b00, req_nk};
            j_d         = 4'd0;
            rcon_d      = 8'h01;
            busy_d      = 1'b1;
            key_valid_d = 1'b0;
            load_en     = 1'b1;
            state_d     = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        wr_en = 1'b1;
        idx_d = idx_q + 6'd1;
        j_d   = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
        if (j_q == 4'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (idx_q == last_q) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          key_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_base = {rk_addr, 2'b00};

  always_comb begin
    rk_data_d = '0;
    if (key_valid_q && rk_addr <= nr_q) begin
      rk_data_d = {words_q[rd_base], words_q[rd_base + 6'd1],
                   words_q[rd_base + 6'd2], words_q[rd_base + 6'd3]};
    end
  end

  // Store has no reset; it is only exposed once key_valid is set.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < MAX_NK; k++) begin
        words_q[k] <= key[32*(MAX_NK-k)-1 -: 32];
      end
    end else if (wr_en) begin
      words_q[idx_q] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 6'd0;
      j_q         <= 4'd0;
      rcon_q      <= 8'h01;
      nk_q        <= 4'd0;
      nr_q        <= 4'd0;
      last_q      <= 6'd0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      nk_q        <= nk_d;
      nr_q        <= nr_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      rk_data_q   <= rk_data_d;
    end
  end

  assign busy       = busy_q;
  assign key_valid  = key_valid_q;
  assign err        = err_q;
  assign num_rounds = nr_q;
  assign rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors plus random keys checked against an
// algebraic key-schedule model (S-box derived from GF(2^8) inversion, not a table).
module tb_aes_key_expand_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    key_len;
  logic [255:0]  key;
  logic          busy, key_valid, err;
  logic [3:0]    num_rounds;
  logic [3:0]    rk_addr;
  logic [127:0]  rk_data;

  logic          start4;
  logic [1:0]    key_len4;
  logic [127:0]  key4;
  logic          busy4, key_valid4, err4;
  logic [3:0]    num_rounds4;
  logic [3:0]    rk_addr4;
  logic [127:0]  rk_data4;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   exp_w [60];
  logic [127:0]  exp_q [$];

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.MAX_NK(8), .RK_W(128)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .key_valid(key_valid), .err(err), .num_rounds(num_rounds),
    .rk_addr(rk_addr), .rk_data(rk_data)
  );

  aes_key_expand_seq #(.MAX_NK(4), .RK_W(128)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .key_len(key_len4), .key(key4),
    .busy(busy4), .key_valid(key_valid4), .err(err4), .num_rounds(num_rounds4),
    .rk_addr(rk_addr4), .rk_data(rk_data4)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p  = 8'h01;
    logic [7:0] sq = a;
    for (int k = 0; k < 8; k++) begin
      if (((254 >> k) & 1) == 1) p = gmul(p, sq);
      sq = gmul(sq, sq);
    end
    ginv = p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    rl = (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] x = ginv(b);
    sbox_ref = x ^ rl(x, 1) ^ rl(x, 2) ^ rl(x, 3) ^ rl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    subw = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
  endfunction

  task automatic build_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = k[255 - 32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int m = 1; m < i / nk; m++) rc = xt(rc);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_kv_low", key_valid, 0);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, exp_lat);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic read_rk(input int r);
    @(negedge clk);
    rk_addr = 4'(r);
    @(negedge clk);
  endtask

  task automatic check_sched(input string tag, input logic [255:0] k, input int nk);
    build_model(k, nk);
    check({tag, "_nr"}, num_rounds, nk + 6);
    for (int r = 0; r <= nk + 6; r++)
      exp_q.push_back({exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]});
    for (int r = 0; r <= nk + 6; r++) begin
      read_rk(r);
      check($sformatf("%s_rk%0d", tag, r), rk_data, exp_q.pop_front());
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [255:0] k1, k2;
    int           kl, nk, n;

    reset = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_addr = 4'd0;
    start4 = 1'b0; key_len4 = 2'd0; key4 = '0; rk_addr4 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_kv", key_valid, 0);
    check("rst_err", err, 0);
    check("rst_nr", num_rounds, 0);
    check("rst_rk", rk_data, 0);
    reset = 1'b0;

    // AES-128 FIPS vector
    do_start(2'd0, {K128, 128'h0});
    wait_valid("lat128", 40);
    check("nr128", num_rounds, 10);
    read_rk(1);
    check("fips128_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10);
    check("fips128_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_sched("m128", {K128, 128'h0}, 4);

    // illegal key_len while DONE
    @(negedge clk);
    key_len = 2'd3; start = 1'b1; rk_addr = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    check("bad_kv", key_valid, 1);
    @(negedge clk);
    check("bad_err_pulse", err, 0);
    check("bad_keep_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(11);
    check("oob_rk11", rk_data, 0);
    read_rk(15);
    check("oob_rk15", rk_data, 0);

    // AES-192 with junk in the ignored LSBs
    do_start(2'd1, {K192, $urandom(), $urandom()});
    wait_valid("lat192", 46);
    check("nr192", num_rounds, 12);
    read_rk(12);
    check("fips192_rk12", rk_data, 128'he98ba06f448c773c8ecc720401002202);

    // AES-256 (j==4 SubWord path)
    do_start(2'd2, K256);
    wait_valid("lat256", 52);
    read_rk(14);
    check("fips256_rk14", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
    check_sched("m256", K256, 8);

    // random keys, all three lengths
    for (int t = 0; t < 6; t++) begin
      kl = $urandom_range(0, 2);
      nk = 4 + 2 * kl;
      k1 = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      do_start(2'(kl), k1);
      wait_valid($sformatf("rnd%0d_lat", t), 4 * (nk + 7) - nk);
      check_sched($sformatf("rnd%0d", t), k1, nk);
    end

    // start re-pulsed mid-EXPAND is ignored
    k1 = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    rk_addr = 4'd0;
    do_start(2'd0, k1);
    n = 0;
    while (!key_valid && n < 200) begin
      if (n == 10) begin
        key = k2; key_len = 2'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n == 11) begin
        check("mid_rd_zero", rk_data, 0);
        check("mid_no_err", err, 0);
        check("mid_busy", busy, 1);
      end
    end
    start = 1'b0;
    check("mid_lat", n, 40);
    check_sched("mid", k1, 4);

    // reset 20 cycles into an expansion, then a fresh start
    do_start(2'd2, k2);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_kv", key_valid, 0);
    check("rstmid_rk", rk_data, 0);
    check("rstmid_nr", num_rounds, 0);
    do_start(2'd1, k2);
    wait_valid("rstmid_lat", 46);
    check_sched("after_rst", k2, 6);

    // MAX_NK=4 build rejects longer keys
    @(negedge clk);
    key_len4 = 2'd2; start4 = 1'b1;
    @(negedge clk);
    check("nk4_err256", err4, 1);
    check("nk4_busy256", busy4, 0);
    key_len4 = 2'd1;
    @(negedge clk);
    check("nk4_err192", err4, 1);
    key_len4 = 2'd0; key4 = K128;
    @(negedge clk);
    start4 = 1'b0;
    check("nk4_accept", busy4, 1);
    check("nk4_no_err", err4, 0);
    n = 0;
    while (!key_valid4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("nk4_lat", n, 40);
    rk_addr4 = 4'd10;
    @(negedge clk);
    check("nk4_rk10", rk_data4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
